countdown_timer: RTL and testbench

- Loadable down-counter timer; the counting-down counterpart of the free-running up counter.
- Software or an FSM loads a start value and issues start. The block decrements once every PRESCALE clocks and pulses done when it reaches zero.
- Used as a timeout/delay generator next to the existing counter blocks; single clock domain.

---
 rtl/countdown_timer.sv | 131 +++++++++++++
 tb/tb_countdown_timer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter, one decrement every PRESCALE clocks, done pulse at zero.
// Latency: busy rises on the edge after start; done follows edge start+V*PRESCALE. Option macro: COUNTDOWN_AUTO_RELOAD_EN.
// No backpressure: stop pauses, load aborts, inputs prioritised rst > load > stop > start.
module countdown_timer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   // PRESCALE is legal from 1 to 255, so an 8-bit tick counter always suffices.
   localparam logic [7:0]       PRE_MAX = 8'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [7:0]       pre_q, pre_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      pre_d    = pre_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      if (load) begin
         state_d  = IDLE;
         count_d  = load_value;
         pre_d    = '0;
         busy_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_d = load_value;
`endif
      end else begin
         case (state_q)
            RUN: begin
               if (stop) begin
                  state_d = PAUSED;
                  busy_d  = 1'b0;
               end else if (pre_q == PRE_MAX) begin
                  pre_d = '0;
                  // Terminal test uses <= so a zero count can never wrap to all-ones.
                  if (count_q <= ONE) begin
                     done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                     if (reload_q != '0) begin
                        count_d = reload_q;
                     end else begin
                        count_d = '0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                     end
`else
                     count_d = '0;
                     state_d = IDLE;
                     busy_d  = 1'b0;
`endif
                  end else begin
                     count_d = count_q - ONE;
                  end
               end else begin
                  pre_d = pre_q + 8'd1;
               end
            end
            default: begin
               if (start && !stop) begin
                  if (count_q != '0) begin
                     state_d = RUN;
                     busy_d  = 1'b1;
                     if (state_q == IDLE) begin
                        pre_d = '0;
                     end
                  end else begin
                     // Zero-length timeout: report completion without ever running.
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         pre_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         pre_q    <= pre_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
         reload_q <= reload_d;
`endif
      end
   end

   assign count_out = count_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (PRESCALE 1 and 4) share stimulus and are compared
// against an elapsed-time reference model every cycle, plus directed constant checks.
module tb_countdown_timer;

   localparam int W = 8;
   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSED = 2;

   logic         clk;
   logic         rst;
   logic         load;
   logic [W-1:0] load_value;
   logic         start;
   logic         stop;
   logic [W-1:0] c1, c4;
   logic         b1, b4, d1, d4;
   logic [2*W+3:0] obs;

   int n_run  = 0;
   int n_fail = 0;

   countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut_p1 (
      .clk(clk), .rst(rst), .load(load), .load_value(load_value),
      .start(start), .stop(stop), .count_out(c1), .busy(b1), .done(d1)
   );

   countdown_timer #(.WIDTH(W), .PRESCALE(4)) dut_p4 (
      .clk(clk), .rst(rst), .load(load), .load_value(load_value),
      .start(start), .stop(stop), .count_out(c4), .busy(b4), .done(d4)
   );

   assign obs = {c1, b1, d1, c4, b4, d4};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: count = loaded value minus whole prescale periods of RUN time elapsed.
   int m_base [2] = '{0, 0};
   int m_el   [2] = '{0, 0};
   int m_mode [2] = '{M_IDLE, M_IDLE};
   bit m_done [2] = '{1'b0, 1'b0};

   function automatic int ps(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   function automatic logic [W-1:0] m_count(input int i);
      return W'(m_base[i] - m_el[i] / ps(i));
   endfunction

   function automatic logic [2*W+3:0] model_vec();
      return {m_count(0), m_mode[0] == M_RUN, m_done[0], m_count(1), m_mode[1] == M_RUN, m_done[1]};
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         m_done[i] = 1'b0;
         if (rst) begin
            m_mode[i] = M_IDLE; m_base[i] = 0; m_el[i] = 0;
         end else if (load) begin
            m_mode[i] = M_IDLE; m_base[i] = int'(load_value); m_el[i] = 0;
         end else if (m_mode[i] == M_RUN) begin
            if (stop) begin
               m_mode[i] = M_PAUSED;
            end else begin
               m_el[i] = m_el[i] + 1;
               if (m_el[i] == m_base[i] * ps(i)) begin
                  m_done[i] = 1'b1;
                  m_el[i]   = 0;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
                  m_base[i] = 0;
                  m_mode[i] = M_IDLE;
`endif
               end
            end
         end else if (start && !stop) begin
            if (m_count(i) != 0) m_mode[i] = M_RUN;
            else m_done[i] = 1'b1;
         end
      end
   end

   task automatic step(input logic r, input logic l, input logic [W-1:0] v,
                       input logic sa, input logic so);
      rst = r; load = l; load_value = v; start = sa; stop = so;
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      n_run++;
      if (obs !== '0) begin n_fail++; $display("FAIL reset_clear: got %h expected 0", obs); end
      for (int k = 0; k < 12; k++) begin
         step(0, 1'($urandom), W'($urandom_range(0, 9)), 1'($urandom), 1'($urandom));
         n_run++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL reset_prelude cyc %0d: got %h expected %h", k, obs, model_vec()); end
      end
      step(1, 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      n_run++;
      if (obs !== '0) begin n_fail++; $display("FAIL reset_after_random: got %h expected 0", obs); end
      step(1, 1, 8'hA5, 1, 0);
      n_run++;
      if ({c1, c4} !== '0) begin n_fail++; $display("FAIL reset_over_load: got %h %h expected 0 0", c1, c4); end
   endtask

   task automatic test_basic();
      step(0, 1, 8'd5, 0, 0);
      step(0, 0, 0, 1, 0);
      n_run++;
      if ({c1, b1, d1} !== {8'd5, 1'b1, 1'b0}) begin n_fail++; $display("FAIL basic_start: got %h/%b/%b expected 05/1/0", c1, b1, d1); end
      for (int k = 1; k <= 6; k++) begin
         step(0, 0, 0, 0, 0);
         n_run++;
         if ({c1, b1, d1} !== {W'((k > 5) ? 0 : 5 - k), k < 5, k == 5}) begin
            n_fail++; $display("FAIL basic_k%0d: got %h/%b/%b", k, c1, b1, d1);
         end
         n_run++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL basic_model k%0d: got %h expected %h", k, obs, model_vec()); end
      end
   endtask

   task automatic test_prescale();
      int busy_cnt;
      busy_cnt = 0;
      step(0, 1, 8'd3, 0, 0);
      step(0, 0, 0, 1, 0);
      if (b4) busy_cnt++;
      for (int k = 1; k <= 14; k++) begin
         step(0, 0, 0, 0, 0);
         if (b4) busy_cnt++;
         n_run++;
         if ({c4, d4} !== {W'(3 - ((k > 12) ? 12 : k) / 4), k == 12}) begin
            n_fail++; $display("FAIL prescale_k%0d: got %h/%b", k, c4, d4);
         end
         n_run++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL prescale_model k%0d: got %h expected %h", k, obs, model_vec()); end
      end
      n_run++;
      if (busy_cnt !== 12) begin n_fail++; $display("FAIL prescale_busy_len: got %0d expected 12", busy_cnt); end
   endtask

   task automatic test_pause();
      logic [W-1:0] held;
      step(0, 1, 8'd10, 0, 0);
      step(0, 0, 0, 1, 0);
      for (int k = 1; k <= 14; k++) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      n_run++;
      if ({c4, b4} !== {8'd7, 1'b0}) begin n_fail++; $display("FAIL pause_stop: got %h/%b expected 07/0", c4, b4); end
      for (int k = 0; k < 20; k++) begin
         step(0, 0, 0, 0, 0);
         n_run++;
         if ({c4, b4} !== {8'd7, 1'b0} || obs !== model_vec()) begin
            n_fail++; $display("FAIL pause_hold k%0d: got %h expected %h", k, obs, model_vec());
         end
      end
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      n_run++;
      if ({c4, b4} !== {8'd7, 1'b1}) begin n_fail++; $display("FAIL resume_first: got %h/%b expected 07/1", c4, b4); end
      step(0, 0, 0, 0, 0);
      n_run++;
      if (c4 !== 8'd6) begin n_fail++; $display("FAIL resume_decrement: got %h expected 06", c4); end
      held = c4;
      step(0, 0, 0, 1, 1);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 0, 0);
         n_run++;
         if ({c4, b4} !== {held, 1'b0} || obs !== model_vec()) begin
            n_fail++; $display("FAIL start_stop_run k%0d: got %h expected %h", k, obs, model_vec());
         end
      end
   endtask

   task automatic test_boundaries();
      step(0, 1, 8'd0, 0, 0);
      step(0, 0, 0, 1, 0);
      n_run++;
      if ({b1, d1, b4, d4} !== 4'b0101) begin n_fail++; $display("FAIL zero_start: got %b expected 0101", {b1, d1, b4, d4}); end
      step(0, 0, 0, 0, 0);
      n_run++;
      if ({b1, d1, b4, d4} !== 4'b0000) begin n_fail++; $display("FAIL zero_after: got %b expected 0000", {b1, d1, b4, d4}); end

      step(0, 1, 8'd255, 0, 0);
      step(0, 0, 0, 1, 0);
      for (int k = 1; k <= 1030; k++) begin
         step(0, 0, 0, 0, 0);
         n_run++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL max_run k%0d: got %h expected %h", k, obs, model_vec()); end
      end
      n_run++;
      if ({c1, b1, c4, b4} !== '0) begin n_fail++; $display("FAIL max_no_wrap: got %h %h expected 0 0", c1, c4); end

      step(0, 1, 8'd2, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 8'h5A, 0, 0);
      n_run++;
      if ({c1, b1, d1} !== {8'h5A, 1'b0, 1'b0}) begin n_fail++; $display("FAIL load_on_terminal: got %h/%b/%b expected 5a/0/0", c1, b1, d1); end

      step(0, 1, 8'd6, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      n_run++;
      if ({c1, b1, c4, b4} !== {8'd4, 1'b1, 8'd6, 1'b1}) begin
         n_fail++; $display("FAIL start_in_run: got %h/%b %h/%b expected 04/1 06/1", c1, b1, c4, b4);
      end
   endtask

   task automatic test_auto_reload();
      step(1, 0, 0, 0, 0);
      step(0, 1, 8'd3, 0, 0);
      step(0, 0, 0, 1, 0);
      for (int k = 1; k <= 9; k++) begin
         step(0, 0, 0, 0, 0);
         n_run++;
         if ({c1, b1, d1} !== {W'(3 - (k % 3)), 1'b1, (k % 3) == 0}) begin
            n_fail++; $display("FAIL reload_k%0d: got %h/%b/%b", k, c1, b1, d1);
         end
         n_run++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL reload_model k%0d: got %h expected %h", k, obs, model_vec()); end
      end
      step(0, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 0);
         n_run++;
         if ({c1, b1, d1} !== {8'd3, 1'b0, 1'b0}) begin n_fail++; $display("FAIL reload_stop k%0d: got %h/%b/%b expected 03/0/0", k, c1, b1, d1); end
      end
      step(1, 0, 0, 1, 0);
      n_run++;
      if (obs !== '0) begin n_fail++; $display("FAIL reload_reset: got %h expected 0", obs); end
      step(0, 0, 0, 1, 0);
      n_run++;
      if ({b1, d1, c1} !== {1'b0, 1'b1, 8'd0}) begin n_fail++; $display("FAIL reload_cleared: got %b/%b/%h expected 0/1/00", b1, d1, c1); end
   endtask

   task automatic test_random();
      logic r, l, sa, so;
      logic [W-1:0] v;
      for (int k = 0; k < 1500; k++) begin
         r  = ($urandom_range(0, 63) == 0);
         l  = ($urandom_range(0, 15) == 0);
         v  = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
         sa = ($urandom_range(0, 3) == 0);
         so = ($urandom_range(0, 9) == 0);
         step(r, l, v, sa, so);
         n_run++;
         if (obs !== model_vec()) begin n_fail++; $display("FAIL random cyc %0d: got %h expected %h", k, obs, model_vec()); end
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0;
      @(negedge clk);
      test_reset();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      test_auto_reload();
`else
      test_basic();
      test_prescale();
      test_pause();
      test_boundaries();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
